onehot_scan_decoder: RTL and testbench

Registered, parametrised N-to-2^N one-hot decoder with enable and an auto-scan mode. It is the sequential successor to the 2x4 decoder with enable. In direct mode it registers the one-hot decode of `a`. In scan mode it steps an internal index through every output, holding each slot for `DWELL` cycles. It drives digit/row-select lines in multiplexed display and keypad logic.

---
 rtl/onehot_scan_decoder.sv | 80 ++++++++
 tb/tb_onehot_scan_decoder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/onehot_scan_decoder.sv
// Registered N-to-2^N one-hot decoder with enable, direct-decode mode and an
// auto-scan mode that steps the index through every slot, holding each for DWELL cycles.
module onehot_scan_decoder #(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     mode,
    input  logic                     load,
    input  logic [SEL_W-1:0]         a,
    output logic [(1 << SEL_W)-1:0]  y,
    output logic [SEL_W-1:0]         idx,
    output logic                     wrap
);

    localparam int unsigned Y_W   = 1 << SEL_W;
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_MAX  = '1;

    logic [Y_W-1:0]   y_q,    y_d;
    logic [SEL_W-1:0] idx_q,  idx_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             wrap_q, wrap_d;
    logic             mode_q, mode_d;

    // Next-state: disabled cycles blank y and freeze idx/cnt/mode_q.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        y_d    = '0;

        if (enable) begin
            if (!mode) begin
                idx_d  = a;
                cnt_d  = '0;
                mode_d = 1'b0;
            end else begin
                // Load or first scan cycle after direct mode/reset restarts from a.
                if (load || !mode_q) begin
                    idx_d = a;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    idx_d  = idx_q + SEL_W'(1);
                    wrap_d = (idx_q == IDX_MAX);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                mode_d = 1'b1;
            end
            y_d = Y_W'(1) << idx_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q    <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            mode_q <= mode_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder: SEL_W=2/DWELL=3 scenarios plus a
// SEL_W=3/DWELL=1 corner instance.
module tb_onehot_scan_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instance A: SEL_W=2, DWELL=3
    logic       rst_a = 1'b1, en_a = 1'b0, mode_a = 1'b0, load_a = 1'b0;
    logic [1:0] a_a = '0;
    logic [3:0] y_a;
    logic [1:0] idx_a;
    logic       wrap_a;

    onehot_scan_decoder #(.SEL_W(2), .DWELL(3)) u_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .mode(mode_a), .load(load_a),
        .a(a_a), .y(y_a), .idx(idx_a), .wrap(wrap_a)
    );

    // Instance B: SEL_W=3, DWELL=1
    logic       rst_b = 1'b1, en_b = 1'b0, mode_b = 1'b0, load_b = 1'b0;
    logic [2:0] a_b = '0;
    logic [7:0] y_b;
    logic [2:0] idx_b;
    logic       wrap_b;

    onehot_scan_decoder #(.SEL_W(3), .DWELL(1)) u_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .mode(mode_b), .load(load_b),
        .a(a_b), .y(y_b), .idx(idx_b), .wrap(wrap_b)
    );

    // Instance A invariant: at most one bit set, and it matches idx when set.
    always @(negedge clk) begin
        if (!rst_a) begin
            chk("a_onehot", 64'($countones(y_a) <= 1), 64'(1));
            if (y_a != 4'b0000)
                chk("a_y_vs_idx", 64'(y_a), 64'(4'b0001 << idx_a));
        end
    end

    task automatic exp_a(input string tag, input logic [3:0] y_e, input logic [1:0] i_e,
                         input logic w_e);
        chk({tag, "_y"},    64'(y_a),    64'(y_e));
        chk({tag, "_idx"},  64'(idx_a),  64'(i_e));
        chk({tag, "_wrap"}, 64'(wrap_a), 64'(w_e));
    endtask

    initial begin
        logic [2:0] ei;

        #12;
        rst_a = 1'b0;
        tick();
        exp_a("rst_idle", 4'b0000, 2'd0, 1'b0);

        // Direct sweep
        en_a = 1'b1; mode_a = 1'b0;
        a_a = 2'd0; tick(); exp_a("dir0", 4'b0001, 2'd0, 1'b0);
        a_a = 2'd1; tick(); exp_a("dir1", 4'b0010, 2'd1, 1'b0);
        a_a = 2'd2; tick(); exp_a("dir2", 4'b0100, 2'd2, 1'b0);
        a_a = 2'd3; tick(); exp_a("dir3", 4'b1000, 2'd3, 1'b0);
        en_a = 1'b0; a_a = 2'd1;
        tick(); exp_a("dir_blank", 4'b0000, 2'd3, 1'b0);

        // Scan rotation from slot 2
        en_a = 1'b1; mode_a = 1'b1; a_a = 2'd2;
        tick(); exp_a("scan_e0", 4'b0100, 2'd2, 1'b0);
        a_a = 2'd0;
        tick(); exp_a("scan_s2b", 4'b0100, 2'd2, 1'b0);
        tick(); exp_a("scan_s2c", 4'b0100, 2'd2, 1'b0);
        tick(); exp_a("scan_s3a", 4'b1000, 2'd3, 1'b0);
        tick(); exp_a("scan_s3b", 4'b1000, 2'd3, 1'b0);
        tick(); exp_a("scan_s3c", 4'b1000, 2'd3, 1'b0);
        tick(); exp_a("scan_s0a", 4'b0001, 2'd0, 1'b1);
        tick(); exp_a("scan_s0b", 4'b0001, 2'd0, 1'b0);
        tick(); exp_a("scan_s0c", 4'b0001, 2'd0, 1'b0);
        tick(); exp_a("scan_s1a", 4'b0010, 2'd1, 1'b0);

        // Freeze after one cycle of slot 1
        en_a = 1'b0; mode_a = 1'b0; load_a = 1'b1; a_a = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick(); exp_a("freeze", 4'b0000, 2'd1, 1'b0);
        end
        en_a = 1'b1; mode_a = 1'b1; load_a = 1'b0; a_a = 2'd0;
        tick(); exp_a("resume_b", 4'b0010, 2'd1, 1'b0);
        tick(); exp_a("resume_c", 4'b0010, 2'd1, 1'b0);
        tick(); exp_a("resume_s2", 4'b0100, 2'd2, 1'b0);
        tick(); tick();
        tick(); exp_a("pre_s3a", 4'b1000, 2'd3, 1'b0);
        tick(); tick(); exp_a("pre_s3c", 4'b1000, 2'd3, 1'b0);

        // Load on the edge where 3 would wrap
        load_a = 1'b1; a_a = 2'd0;
        tick(); exp_a("coll_a", 4'b0001, 2'd0, 1'b0);
        load_a = 1'b0; a_a = 2'd2;
        tick(); exp_a("coll_b", 4'b0001, 2'd0, 1'b0);
        tick(); exp_a("coll_c", 4'b0001, 2'd0, 1'b0);
        tick(); exp_a("coll_next", 4'b0010, 2'd1, 1'b0);

        // Asynchronous reset mid-scan, no clock edge
        #2 rst_a = 1'b1;
        #1 exp_a("async_rst", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rst_a = 1'b0; a_a = 2'd3;
        tick(); exp_a("post_rst_entry", 4'b1000, 2'd3, 1'b0);
        tick(); exp_a("post_rst_hold", 4'b1000, 2'd3, 1'b0);

        // Instance B: DWELL=1 rotation through all 8 slots
        rst_b = 1'b0; en_b = 1'b1; mode_b = 1'b1; a_b = 3'd5;
        tick();
        chk("b_entry_y", 64'(y_b), 64'(8'b0010_0000));
        chk("b_entry_wrap", 64'(wrap_b), 64'(0));
        ei = 3'd5;
        a_b = 3'd0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("b_wrap", 64'(wrap_b), 64'(ei == 3'd7));
            ei = ei + 3'd1;
            chk("b_y", 64'(y_b), 64'(8'b1 << ei));
            chk("b_idx", 64'(idx_b), 64'(ei));
            chk("b_onehot", 64'($countones(y_b)), 64'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
